pluto_spi_host: RTL and testbench
=================================

// Module: pluto_spi_host
// PURPOSE
//  SPI master that drives the pluto servo SPI slave: one transaction = one 20-byte frame,
//  MSB first, SSEL active low. Shifts out PWM/dout/control bytes and captures the returned
//  quadrature counts, din and raw encoder status. Used as FPGA-side host and as the bench
//  driver for the servo firmware.
// PARAMETERS
//  CLKDIV   4   clk cycles per SCK half-period (>=2; must be >= 4 slave clk periods)
//  CSSETUP  4   clk cycles from SSEL falling to first SCK rising edge
//  CSGAP    8   min clk cycles SSEL stays high between frames
// PORTS
//  clk       in   1   system clock, all logic on rising edge
//  RESET     in   1   asynchronous, active-high reset
//  start     in   1   pulse: begin frame (ignored while busy=1)
//  pwm0..3   in   16  PWM words (bit15 dir, 14 pdm, 13/12 invert, 10:0 duty)
//  dout_cmd  in   10  digital output word
//  zpol      in   1   index polarity bit;  qtest in 1  quad test bit
//  MISO      in   1   serial data from slave
//  SCK       out  1   SPI clock, idle low
//  MOSI      out  1   serial data to slave
//  SSEL      out  1   chip select, active low
//  busy      out  1   frame in progress (start..end of CSGAP)
//  done      out  1   one-cycle pulse when rx outputs update
//  quad0..3  out  28  received quadrature words
//  din_rx    out  8   received din byte
//  enc_stat  out  12  {quadA,quadB,quadZ} raw status
// BEHAVIOUR
//  Reset: SSEL=1, SCK=0, MOSI=0, busy=0, done=0, all rx outputs 0, FSM=IDLE; takes effect
//   immediately, aborting any frame (no output update for the aborted frame).
//  start in IDLE: latch pwm0..3/dout_cmd/zpol/qtest into shadow tx regs (later input changes
//   do not affect the frame), busy=1, SSEL=0 next cycle, FSM->SETUP.
//  TX bytes: 0/1 pwm0 lo/hi, 2/3 pwm1, 4/5 pwm2, 6/7 pwm3, 8 dout_cmd[7:0],
//   9 {zpol,1'b0,qtest,3'b0,dout_cmd[9:8]}, 10..19 8'h00.
//  FSM: IDLE -> SETUP(CSSETUP cycles, SCK=0, MOSI=bit7 of byte0) -> HIGH(CLKDIV cycles,
//   SCK=1) -> LOW(CLKDIV cycles, SCK=0) -> HIGH ... for 160 bits -> HOLD(CLKDIV cycles,
//   SCK=0, SSEL=0) -> GAP(SSEL=1, CSGAP cycles) -> IDLE.
//  MOSI changes only on SCK falling edge (entry to LOW); stable through whole HIGH phase.
//  MISO sampled on last clk cycle of each HIGH phase (just before SCK falls).
//  Bit counter 0..159: byte = cnt[7:3], bit = 7-cnt[2:0]; rx shift reg 8 bits, byte
//   committed to frame buffer after 8th sample.
//  RX map: bytes 0..3 -> quad0[7:0],[15:8],[23:16],[27:24]=byte3[3:0]; 4..7 quad1;
//   8..11 quad2; 12..15 quad3; 16 din_rx; 17 -> quadB=[7:4], quadZ=[3:0]; 18 quadA=[3:0];
//   byte 19 and upper nibbles of bytes 3/7/11/15/18 discarded.
//  All rx outputs update together in the cycle SSEL rises (entry to GAP); done=1 that cycle.
//  Frame length: CSSETUP + 320*CLKDIV + CLKDIV + CSGAP clk cycles, start to busy=0.
//  start during busy: ignored, no queueing. start held high: new frame each time IDLE reached.
//  start in same cycle busy falls: accepted (IDLE is evaluated after GAP exits).
// TESTING
//  1 Reset: RESET=1 -> SSEL=1, SCK=0, busy=0, quad0..3=0; release, no start -> SCK never toggles.
//  2 Slave model returns byte k = k+8'h10: one frame -> quad0=28'h3121110, din_rx=8'h20,
//    quadB=4'h2, quadZ=4'h1, quadA=4'h2, done one pulse, exactly 160 SCK rising edges.
//  3 pwm0=16'hA5C3, dout_cmd=10'h2F0, zpol=1, qtest=1 -> slave-captured MOSI bytes 0,1,8,9
//    = C3,A5,F0,A2; bytes 10..19 = 00.
//  4 Change pwm1 mid-frame -> transmitted bytes 2/3 still the value latched at start.
//  5 RESET pulse at bit 50 -> SSEL=1 same cycle, no done, quad outputs keep 0; next frame ok.
//  6 start held high, CLKDIV=2 -> back-to-back frames, SSEL high >= CSGAP cycles between.

Source files
------------

// File: rtl/pluto_spi_host_if.sv
// pluto_spi_host_if
//   Bundles the host-side signals of the pluto servo SPI master: the frame
//   request and transmit words, the serial lines, and the received words.
//   modport master : the SPI host itself (drives SCK/MOSI/SSEL and rx words)
//   modport slave  : the user/bench side (drives start, tx words and MISO)
interface pluto_spi_host_if;
  logic        start;
  logic [15:0] pwm0;
  logic [15:0] pwm1;
  logic [15:0] pwm2;
  logic [15:0] pwm3;
  logic [9:0]  dout_cmd;
  logic        zpol;
  logic        qtest;
  logic        MISO;
  logic        SCK;
  logic        MOSI;
  logic        SSEL;
  logic        busy;
  logic        done;
  logic [27:0] quad0;
  logic [27:0] quad1;
  logic [27:0] quad2;
  logic [27:0] quad3;
  logic [7:0]  din_rx;
  logic [11:0] enc_stat;

  modport master (
    input  start, pwm0, pwm1, pwm2, pwm3, dout_cmd, zpol, qtest, MISO,
    output SCK, MOSI, SSEL, busy, done, quad0, quad1, quad2, quad3, din_rx, enc_stat
  );

  modport slave (
    output start, pwm0, pwm1, pwm2, pwm3, dout_cmd, zpol, qtest, MISO,
    input  SCK, MOSI, SSEL, busy, done, quad0, quad1, quad2, quad3, din_rx, enc_stat
  );
endinterface

// File: rtl/pluto_spi_host.sv
// pluto_spi_host
//   SPI master for the pluto servo slave. Each request sends one 20-byte frame
//   MSB first with SSEL low, shifting out PWM/dout/control bytes and capturing
//   the returned quadrature counts, din byte and raw encoder status.
// Ports
//   clk   : system clock, rising edge
//   RESET : asynchronous active-high reset, aborts any frame in flight
//   bus   : pluto_spi_host_if.master (start/tx words in, SPI lines, rx words out)
module pluto_spi_host #(
  parameter int CLKDIV  = 4,
  parameter int CSSETUP = 4,
  parameter int CSGAP   = 8
) (
  input  logic                     clk,
  input  logic                     RESET,
  pluto_spi_host_if.master         bus
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

  localparam logic [15:0] SETUP_LEN = 16'(CSSETUP - 1);
  localparam logic [15:0] HALF_LEN  = 16'(CLKDIV - 1);
  localparam logic [15:0] GAP_LEN   = 16'(CSGAP - 1);
  localparam logic [7:0]  LAST_BIT  = 8'd160;

  state_t      state_reg;
  logic [15:0] div_cnt_reg;
  logic [7:0]  bit_cnt_reg;   // index of the bit currently on MOSI
  logic [7:0]  rx_sh_reg;
  logic [79:0] tx_shadow_reg; // bytes 0..9; bytes 10..19 are always zero
  logic [7:0]  rx_buf [19];   // byte 19 is never needed

  logic        sample_last;
  logic [7:0]  rx_byte;
  logic [27:0] quad_word [4];

  // Final sample of the HIGH phase; completes a byte every eighth bit.
  assign sample_last = (state_reg == HIGH) && (div_cnt_reg == 16'd0);
  assign rx_byte     = {rx_sh_reg[6:0], bus.MISO};

  for (genvar gi = 0; gi < 4; gi++) begin : g_quad
    assign quad_word[gi] = {rx_buf[4*gi+3][3:0], rx_buf[4*gi+2],
                            rx_buf[4*gi+1], rx_buf[4*gi]};
  end

  // Bit idx of the frame: byte idx[7:3], bit 7-idx[2:0] (which is ~idx[2:0]).
  function automatic logic tx_bit(input logic [7:0] idx);
    if (idx < 8'd80)
      return tx_shadow_reg[{idx[6:3], ~idx[2:0]}];
    return 1'b0;
  endfunction

  // Data-only storage: no reset needed, outputs are gated by the FSM.
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && bus.start)
      tx_shadow_reg <= {bus.zpol, 1'b0, bus.qtest, 3'b000, bus.dout_cmd[9:8],
                        bus.dout_cmd[7:0], bus.pwm3, bus.pwm2, bus.pwm1, bus.pwm0};
    if (sample_last && bit_cnt_reg[2:0] == 3'd7 && bit_cnt_reg[7:3] < 5'd19)
      rx_buf[bit_cnt_reg[7:3]] <= rx_byte;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_reg    <= IDLE;
      div_cnt_reg  <= 16'd0;
      bit_cnt_reg  <= 8'd0;
      rx_sh_reg    <= 8'd0;
      bus.SCK      <= 1'b0;
      bus.MOSI     <= 1'b0;
      bus.SSEL     <= 1'b1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.quad0    <= 28'd0;
      bus.quad1    <= 28'd0;
      bus.quad2    <= 28'd0;
      bus.quad3    <= 28'd0;
      bus.din_rx   <= 8'd0;
      bus.enc_stat <= 12'd0;
    end else begin
      bus.done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg   <= SETUP;
            bus.busy    <= 1'b1;
            bus.SSEL    <= 1'b0;
            bus.SCK     <= 1'b0;
            // Shadow is loaded this same edge, so take bit 7 of byte 0 directly.
            bus.MOSI    <= bus.pwm0[7];
            bit_cnt_reg <= 8'd0;
            div_cnt_reg <= SETUP_LEN;
          end
        end
        SETUP: begin
          if (div_cnt_reg == 16'd0) begin
            state_reg   <= HIGH;
            bus.SCK     <= 1'b1;
            div_cnt_reg <= HALF_LEN;
          end else begin
            div_cnt_reg <= div_cnt_reg - 16'd1;
          end
        end
        HIGH: begin
          if (div_cnt_reg == 16'd0) begin
            rx_sh_reg   <= rx_byte;
            state_reg   <= LOW;
            bus.SCK     <= 1'b0;
            bus.MOSI    <= tx_bit(bit_cnt_reg + 8'd1);
            bit_cnt_reg <= bit_cnt_reg + 8'd1;
            div_cnt_reg <= HALF_LEN;
          end else begin
            div_cnt_reg <= div_cnt_reg - 16'd1;
          end
        end
        LOW: begin
          if (div_cnt_reg == 16'd0) begin
            div_cnt_reg <= HALF_LEN;
            // Every bit, including the last, gets a full LOW phase before HOLD.
            if (bit_cnt_reg == LAST_BIT) begin
              state_reg <= HOLD;
            end else begin
              state_reg <= HIGH;
              bus.SCK   <= 1'b1;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg - 16'd1;
          end
        end
        HOLD: begin
          if (div_cnt_reg == 16'd0) begin
            state_reg    <= GAP;
            bus.SSEL     <= 1'b1;
            bus.done     <= 1'b1;
            div_cnt_reg  <= GAP_LEN;
            bus.quad0    <= quad_word[0];
            bus.quad1    <= quad_word[1];
            bus.quad2    <= quad_word[2];
            bus.quad3    <= quad_word[3];
            bus.din_rx   <= rx_buf[16];
            bus.enc_stat <= {rx_buf[18][3:0], rx_buf[17][7:4], rx_buf[17][3:0]};
          end else begin
            div_cnt_reg <= div_cnt_reg - 16'd1;
          end
        end
        GAP: begin
          if (div_cnt_reg == 16'd0) begin
            state_reg <= IDLE;
            bus.busy  <= 1'b0;
          end else begin
            div_cnt_reg <= div_cnt_reg - 16'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pluto_spi_host.sv
// tb_pluto_spi_host
//   Directed bench for pluto_spi_host: a behavioural SPI slave answers byte k
//   with k+8'h10 and captures MOSI bytes; a table of tx vectors is run frame by
//   frame, followed by hand-written mid-frame, reset-abort and back-to-back cases.
module tb_pluto_spi_host;

  localparam int FRAME_BUSY = 4 + 321*4 + 8;   // CSSETUP + 321*CLKDIV + CSGAP
  localparam int PERIOD2    = 4 + 321*2 + 8 + 1; // back-to-back at CLKDIV=2, incl. IDLE cycle

  logic clk;
  logic RESET;

  pluto_spi_host_if bus ();
  pluto_spi_host_if bus2 ();

  pluto_spi_host dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  pluto_spi_host #(.CLKDIV(2), .CSSETUP(4), .CSGAP(8)) dut2 (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pwm0;
    logic [15:0] pwm1;
    logic [15:0] pwm2;
    logic [15:0] pwm3;
    logic [9:0]  dout;
    logic        zpol;
    logic        qtest;
    logic [79:0] exp_tx; // byte 9 .. byte 0
  } vec_t;

  vec_t vecs [3];

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor / slave model state (written only by the monitor process).
  int         sck_rises = 0;
  int         done_cnt  = 0;
  int         busy_cyc  = 0;
  int         rcnt      = 0;
  logic       prev_sck  = 1'b0;
  logic [7:0] mosi_bytes [20];

  int   cyc        = 0;
  int   f2         = 0;
  int   last_fall2 = 0;
  int   period2    = 0;
  int   gap2       = 0;
  int   min_gap2   = 1000000;
  int   hi_run2    = 0;
  logic prev_ssel2 = 1'b1;

  function automatic logic resp_bit(input int r);
    logic [7:0] b;
    b = 8'((r >> 3) + 16);
    return b[7 - (r & 7)];
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (bus.done === 1'b1) done_cnt++;
    if (bus.busy === 1'b1) busy_cyc++;
    if (bus.SSEL !== 1'b0) begin
      rcnt     = 0;
      bus.MISO = resp_bit(0);
    end else if (prev_sck == 1'b0 && bus.SCK == 1'b1) begin
      sck_rises++;
      if (rcnt < 160) mosi_bytes[rcnt/8] = {mosi_bytes[rcnt/8][6:0], bus.MOSI};
      rcnt++;
    end else if (prev_sck == 1'b1 && bus.SCK == 1'b0) begin
      bus.MISO = resp_bit(rcnt);
    end
    prev_sck = bus.SCK;

    if (prev_ssel2 == 1'b1 && bus2.SSEL == 1'b0) begin
      if (f2 > 0) begin
        period2 = cyc - last_fall2;
        gap2    = hi_run2;
        if (hi_run2 < min_gap2) min_gap2 = hi_run2;
      end
      last_fall2 = cyc;
      f2++;
    end
    hi_run2    = (bus2.SSEL == 1'b1) ? hi_run2 + 1 : 0;
    prev_ssel2 = bus2.SSEL;
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic apply_vec(input int i);
    bus.pwm0     = vecs[i].pwm0;
    bus.pwm1     = vecs[i].pwm1;
    bus.pwm2     = vecs[i].pwm2;
    bus.pwm3     = vecs[i].pwm3;
    bus.dout_cmd = vecs[i].dout;
    bus.zpol     = vecs[i].zpol;
    bus.qtest    = vecs[i].qtest;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Runs one frame with vector i; optionally rewrites pwm1 mid-frame.
  task automatic run_frame(input int i, input bit mid_change, input string tag);
    int s0, d0, b0;
    logic [79:0] got_tx;
    logic [79:0] got_hi;
    apply_vec(i);
    s0 = sck_rises; d0 = done_cnt; b0 = busy_cyc;
    pulse_start();
    if (mid_change) begin
      repeat (20) @(negedge clk);
      bus.pwm1 = 16'hBEEF;
    end
    for (int k = 0; k < 3000 && bus.busy !== 1'b0; k++) @(negedge clk);
    check({tag, " busy end"}, 80'(bus.busy), 80'(1'b0));
    @(negedge clk);
    got_tx = '0;
    got_hi = '0;
    for (int b = 0; b < 10; b++) got_tx[b*8 +: 8] = mosi_bytes[b];
    for (int b = 10; b < 20; b++) got_hi[(b-10)*8 +: 8] = mosi_bytes[b];
    check({tag, " mosi bytes0-9"}, got_tx, vecs[i].exp_tx);
    check({tag, " mosi bytes10-19"}, got_hi, 80'd0);
    check({tag, " sck rises"}, 80'(sck_rises - s0), 80'd160);
    check({tag, " done pulses"}, 80'(done_cnt - d0), 80'd1);
    check({tag, " busy cycles"}, 80'(busy_cyc - b0), 80'(FRAME_BUSY));
    check({tag, " quad0"}, 80'(bus.quad0), 80'h3121110);
    check({tag, " quad1"}, 80'(bus.quad1), 80'h7161514);
    check({tag, " quad2"}, 80'(bus.quad2), 80'hB1A1918);
    check({tag, " quad3"}, 80'(bus.quad3), 80'hF1E1D1C);
    check({tag, " din_rx"}, 80'(bus.din_rx), 80'h20);
    check({tag, " enc_stat"}, 80'(bus.enc_stat), 80'h221);
    $display("%s: tx=%h quad0=%h din=%h enc=%h", tag, got_tx, bus.quad0, bus.din_rx, bus.enc_stat);
  endtask

  initial begin
    int s0, d0;
    vecs[0] = '{pwm0:16'hA5C3, pwm1:16'h1234, pwm2:16'h0000, pwm3:16'hFFFF,
                dout:10'h2F0, zpol:1'b1, qtest:1'b1,
                exp_tx:80'hA2F0_FFFF_0000_1234_A5C3};
    vecs[1] = '{pwm0:16'h0001, pwm1:16'h8000, pwm2:16'h7FFF, pwm3:16'h4321,
                dout:10'h155, zpol:1'b0, qtest:1'b1,
                exp_tx:80'h2155_4321_7FFF_8000_0001};
    vecs[2] = '{pwm0:16'h0000, pwm1:16'h0000, pwm2:16'h0000, pwm3:16'h0000,
                dout:10'h3FF, zpol:1'b1, qtest:1'b0,
                exp_tx:80'h83FF_0000_0000_0000_0000};

    bus.start = 1'b0;
    apply_vec(0);
    bus2.start = 1'b0; bus2.pwm0 = '0; bus2.pwm1 = '0; bus2.pwm2 = '0; bus2.pwm3 = '0;
    bus2.dout_cmd = '0; bus2.zpol = 1'b0; bus2.qtest = 1'b0; bus2.MISO = 1'b0;
    RESET = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst SSEL", 80'(bus.SSEL), 80'(1'b1));
    check("rst SCK", 80'(bus.SCK), 80'(1'b0));
    check("rst MOSI", 80'(bus.MOSI), 80'(1'b0));
    check("rst busy", 80'(bus.busy), 80'(1'b0));
    check("rst done", 80'(bus.done), 80'(1'b0));
    check("rst quads", {bus.quad0, bus.quad1, bus.din_rx, bus.enc_stat}, 80'd0);
    check("rst quad2/3", 80'({bus.quad2, bus.quad3}), 80'd0);
    RESET = 1'b0;
    s0 = sck_rises;
    repeat (50) @(negedge clk);
    check("idle sck quiet", 80'(sck_rises - s0), 80'd0);
    check("idle SSEL", 80'(bus.SSEL), 80'(1'b1));

    // Reset at bit 50 aborts the frame
    d0 = done_cnt;
    pulse_start();
    for (int k = 0; k < 3000 && rcnt < 50; k++) @(negedge clk);
    check("abort reached bit 50", 80'(rcnt >= 50), 80'd1);
    RESET = 1'b1;
    #1;
    check("abort SSEL immediate", 80'(bus.SSEL), 80'(1'b1));
    check("abort busy immediate", 80'(bus.busy), 80'(1'b0));
    @(negedge clk);
    RESET = 1'b0;
    s0 = sck_rises;
    repeat (1500) @(negedge clk);
    check("abort no done", 80'(done_cnt - d0), 80'd0);
    check("abort no sck", 80'(sck_rises - s0), 80'd0);
    check("abort quad0", 80'(bus.quad0), 80'd0);
    $display("abort at bit 50: SSEL=%b quad0=%h", bus.SSEL, bus.quad0);

    // Table of full frames
    for (int i = 0; i < 3; i++) run_frame(i, 1'b0, $sformatf("vec%0d", i));

    // pwm1 rewritten mid-frame; the latched value must still go out
    run_frame(0, 1'b1, "midchange");

    // Back-to-back frames with start held high, CLKDIV=2
    bus2.start = 1'b1;
    for (int k = 0; k < 5000 && f2 < 4; k++) @(negedge clk);
    bus2.start = 1'b0;
    check("b2b frames seen", 80'(f2 >= 4), 80'd1);
    check("b2b period", 80'(period2), 80'(PERIOD2));
    check("b2b gap", 80'(gap2), 80'd9);
    check("b2b min gap>=CSGAP", 80'(min_gap2 >= 8), 80'd1);
    $display("back-to-back: frames=%0d period=%0d gap=%0d", f2, period2, gap2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
